// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute-stage control path and the
// iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDCtl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] MDResult;

    modport master (
        output start, MDCtl, SrcA, SrcB,
        input  busy, done, MDResult
    );

    modport slave (
        input  start, MDCtl, SrcA, SrcB,
        output busy, done, MDResult
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, magnitudes in, sign fix-up on the last step.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic [1:0]       state_q;
    logic [CW-1:0]    count_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] m_q;       // value added (multiplicand) or subtracted (divisor)
    logic [WIDTH-1:0] hi_q;      // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;      // multiplier bits / dividend bits, becoming product low / quotient
    logic [WIDTH-1:0] a_q;
    logic             neg_q;
    logic             rneg_q;
    logic             dz_q;
    logic             ovf_q;
    logic [WIDTH-1:0] md_result_q;

    // Accept-time operand decode
    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_sgn = (bus.MDCtl == OP_MULH) || (bus.MDCtl == OP_MULHSU) ||
                (bus.MDCtl == OP_DIV)  || (bus.MDCtl == OP_REM);
        b_sgn = (bus.MDCtl == OP_MULH) || (bus.MDCtl == OP_DIV) || (bus.MDCtl == OP_REM);
        a_neg = a_sgn & bus.SrcA[WIDTH-1];
        b_neg = b_sgn & bus.SrcB[WIDTH-1];
        a_mag = a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
        b_mag = b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
    end

    // One iteration of the shared core
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   result_fin;

    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shifted = {hi_q, lo_q[WIDTH-1]};
        div_diff    = div_shifted - {1'b0, m_q};
        div_ge      = ~div_diff[WIDTH];
        hi_n        = mul_sum[WIDTH:1];
        lo_n        = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (op_q[2]) begin
            hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], div_ge};
        end

        prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo_fix  = neg_q  ? -lo_n : lo_n;
        rem_fix  = rneg_q ? -hi_n : hi_n;

        result_fin = prod_fix[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:            result_fin = prod_fix[WIDTH-1:0];
            OP_DIV, OP_DIVU:   result_fin = dz_q ? '1 : (ovf_q ? a_q : quo_fix);
            OP_REM, OP_REMU:   result_fin = dz_q ? a_q : (ovf_q ? '0 : rem_fix);
            default:           result_fin = prod_fix[2*WIDTH-1:WIDTH];
        endcase
    end

    // NOTE: all state, datapath registers included, is cleared by the async
    // reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            op_q        <= '0;
            m_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            a_q         <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            md_result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of its peers.
            case (state_q)
                S_RUN: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    if (count_q == LAST) begin
                        state_q     <= S_DONE;
                        md_result_q <= result_fin;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        count_q <= '0;
                        op_q    <= bus.MDCtl;
                        hi_q    <= '0;
                        m_q     <= bus.MDCtl[2] ? b_mag : a_mag;
                        lo_q    <= bus.MDCtl[2] ? a_mag : b_mag;
                        a_q     <= bus.SrcA;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        dz_q    <= (bus.SrcB == '0);
                        ovf_q   <= bus.MDCtl[2] && !bus.MDCtl[0] &&
                                   (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                   (bus.SrcB == '1);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.MDResult = md_result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, latency and pulse width,
// ignored starts while busy, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_cnt     = 0;
    int accept_edge  = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.MDCtl = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(posedge clk);
        #1;
        accept_edge = edge_cnt;
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] res, output int lat);
        while (bus.done !== 1'b1 && (edge_cnt - accept_edge) < 100) begin
            @(posedge clk);
            #1;
        end
        lat = edge_cnt - accept_edge;
        res = bus.MDResult;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        accept_op(op, a, b);
        wait_done(res, lat);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.MDCtl = 3'd0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b expected 0", bus.done);
        end
        tests_run++;
        if (bus.MDResult !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 00000000", bus.MDResult);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [2:0]  v_op  [17] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5,
                                   3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd6, 3'd1, 3'd3};
        logic [31:0] v_a   [17] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                   32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                   32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] v_b   [17] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                                   32'hFFFFFFFE, 32'd5, 32'd5};
        logic [31:0] v_exp [17] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                   32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF,
                                   32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                   32'd1, 32'hFFFFFFFF, 32'd4};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 17; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], res, lat);
            tests_run++;
            if (res !== v_exp[i]) begin
                tests_failed++;
                $display("FAIL arith_result[%0d] op=%0d a=%h b=%h: got %h expected %h",
                         i, v_op[i], v_a[i], v_b[i], res, v_exp[i]);
            end
            tests_run++;
            if (lat !== 32) begin
                tests_failed++;
                $display("FAIL arith_latency[%0d]: got %0d edges after accept, expected 32", i, lat);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.done !== 1'b0 || bus.MDResult !== v_exp[i]) begin
                tests_failed++;
                $display("FAIL arith_pulse_hold[%0d]: got done=%b result=%h expected done=0 result=%h",
                         i, bus.done, bus.MDResult, v_exp[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] res;
        int          lat;
        @(negedge clk);
        accept_op(3'd5, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.MDCtl = 3'($urandom_range(0, 7));
            bus.SrcA  = $urandom;
            bus.SrcB  = $urandom;
            @(negedge clk);
            bus.start = 1'b0;
        end
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_busy_flag: got %b expected 1", bus.busy);
        end
        wait_done(res, lat);
        tests_run++;
        if (res !== 32'd14) begin
            tests_failed++;
            $display("FAIL ignore_result: got %h expected 0000000e", res);
        end
        tests_run++;
        if (lat !== 32) begin
            tests_failed++;
            $display("FAIL ignore_latency: got %0d expected 32", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        @(negedge clk);
        accept_op(3'd0, 32'd7, 32'hFFFFFFFD);
        wait_done(res, lat);
        tests_run++;
        if (res !== 32'hFFFFFFEB || lat !== 32) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h lat %0d expected ffffffeb lat 32", res, lat);
        end
        accept_op(3'd3, 32'hFFFFFFFF, 32'd5);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1",
                     bus.done, bus.busy);
        end
        wait_done(res, lat);
        tests_run++;
        if (res !== 32'd4) begin
            tests_failed++;
            $display("FAIL b2b_second_result: got %h expected 00000004", res);
        end
        tests_run++;
        if (lat !== 32) begin
            tests_failed++;
            $display("FAIL b2b_second_latency: got %0d expected 32", lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        int          done_seen = 0;
        @(negedge clk);
        accept_op(3'd0, 32'd7, 32'hFFFFFFFD);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.MDResult !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_async: got busy=%b done=%b result=%h expected 0/0/00000000",
                     bus.busy, bus.done, bus.MDResult);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_done: got %0d done cycles expected 0", done_seen);
        end
        rst_n = 1'b1;
        run_op(3'd7, 32'd100, 32'd7, res, lat);
        tests_run++;
        if (res !== 32'd2 || lat !== 32) begin
            tests_failed++;
            $display("FAIL midreset_recover: got %h lat %0d expected 00000002 lat 32", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
